ifu_mem_responder: RTL
======================

Name: ifu_mem_responder

Overview:
- Memory-side responder for the PDP-8 instruction-fetch interface. It answers the IFD's ifu_rd_req/ifu_rd_addr with ifu_rd_data after a programmable latency, qualified by a valid pulse.
- It also serves a single-cycle read/write port for the execution unit (priority over fetch) and a program-load port.
- It sits between the IFD and the unit-level bench or top, and replaces the ideal memory model on the fetch path.

Parameters:
- ADDR_WIDTH, 12, word-address width (`ADDR_WIDTH); memory depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 12, word width (`DATA_WIDTH).
- RD_LATENCY, 2, fetch latency in cycles; legal range 1..7.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ifu_rd_req  in  1  fetch request from IFD; held until accepted.
- ifu_rd_addr  in  ADDR_WIDTH  fetch address.
- ifu_rd_data  out  DATA_WIDTH  fetched instruction word.
- ifu_rd_valid  out  1  one-cycle pulse; ifu_rd_data is valid.
- ifu_busy  out  1  fetch request cannot be accepted this cycle.
- exec_rd_req  in  1  exec-unit read.
- exec_wr_req  in  1  exec-unit write.
- exec_addr  in  ADDR_WIDTH  exec-unit address.
- exec_wr_data  in  DATA_WIDTH  exec-unit write data.
- exec_rd_data  out  DATA_WIDTH  exec-unit read data.
- exec_rd_valid  out  1  one-cycle pulse; exec_rd_data is valid.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_WIDTH  load address.
- load_data  in  DATA_WIDTH  load data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset:
  - State goes to IDLE; latency counter cleared.
  - ifu_rd_data=0, ifu_rd_valid=0, exec_rd_data=0, exec_rd_valid=0.
  - Memory array is not cleared.
  - Reset during WAIT or RESP drops the pending fetch; no ifu_rd_valid is produced for it.
- Priority per cycle: load_en > exec_wr_req > exec_rd_req > fetch accept.
  - Any load or exec access in a cycle blocks fetch acceptance in that cycle.
- Load port: load_en=1 writes load_data to load_addr at the posedge. Exec requests in the same cycle are ignored, with no exec_rd_valid.
- Exec port:
  - exec_wr_req writes at the posedge.
  - exec_rd_req (without wr) registers mem[exec_addr] into exec_rd_data and pulses exec_rd_valid the next cycle.
  - rd and wr asserted together: write wins, no exec_rd_valid.
  - exec_rd_data holds its value between reads.
- Fetch FSM states: IDLE, WAIT, RESP.
  - IDLE or RESP, with ifu_rd_req=1 and no load/exec access this cycle: accept. The accepted data is mem[ifu_rd_addr] read at the accept edge, after any same-edge write is excluded because that cycle is blocked. Data goes to an internal holding register.
  - On accept, counter loads RD_LATENCY-1. If RD_LATENCY=1, next state is RESP; otherwise WAIT.
  - WAIT: decrement counter each cycle; go to RESP when counter reaches 1 (i.e. stays RD_LATENCY-1 cycles total in WAIT).
  - RESP: ifu_rd_valid=1 and ifu_rd_data = holding register, for exactly one cycle. Next state is IDLE, or a new accept (WAIT/RESP) if a request is accepted this cycle.
- Latency: request accepted at edge N gives ifu_rd_valid high during the cycle after edge N+RD_LATENCY-1. With RD_LATENCY=1, valid is in the cycle immediately after accept.
- Data snapshot: the snapshot is taken at accept. Writes to the same address during WAIT are not reflected in the returned word.
- ifu_rd_data holds the last fetched word after valid drops, until the next RESP.
- ifu_busy = (state==WAIT) | load_en | exec_rd_req | exec_wr_req. This is combinational.
  - IFD must hold ifu_rd_req and ifu_rd_addr while busy.
  - Requests while in WAIT are ignored; they are not queued.
- Throughput: one fetch per RD_LATENCY cycles (back-to-back accept in RESP).
- Addresses: full ADDR_WIDTH range; 12'hFFF is valid with no wrap logic. There are no out-of-range cases.

Test Plan:
1. Basic fetch: load 12'h080=12'hE01 (IAC), RD_LATENCY=2; ifu_rd_req addr 080 accepted at edge N -> ifu_rd_valid=1 only in the cycle after edge N+1; ifu_rd_data=E01; busy=1 during WAIT.
2. Fetch/exec conflict: exec_wr_req addr 081 data A05 in the same cycle as ifu_rd_req addr 081 -> busy=1, no accept. Next cycle the fetch is accepted and returns A05.
3. Back-to-back fetches: RD_LATENCY=1, addr 100 then 101 holding 12'h200 and 12'h401 -> valid on two consecutive cycles with data 200 then 401.
4. Reset mid-operation: reset asserted while in WAIT for addr 080 -> no valid pulse; all outputs 0. A subsequent fetch of 080 returns E01 (memory retained).
5. Exec rd+wr simultaneously: addr 050, wr data 777 -> no exec_rd_valid. A later exec read of 050 returns 777 one cycle after the request.
6. Boundary address and write-after-accept: load 12'hFFF=12'h123, fetch FFF, exec write FFF=456 during WAIT -> returned word 123.

Source files
------------

// File: rtl/ifu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : ifu_mem_responder
// Purpose  : Memory-side responder for the PDP-8 instruction-fetch path.
//            Returns ifu_rd_data with a one-cycle ifu_rd_valid pulse
//            RD_LATENCY cycles after a fetch is accepted. Also provides a
//            single-cycle exec-unit read/write port and a program-load port.
//            Per-cycle priority: load > exec write > exec read > fetch.
// Ports    : clk, reset                  - clock, synchronous active-high reset
//            ifu_rd_req/addr             - fetch request (held while busy)
//            ifu_rd_data/valid           - fetched word, one-cycle valid pulse
//            ifu_busy                    - fetch cannot be accepted this cycle
//            exec_rd_req/wr_req/addr/
//            exec_wr_data                - exec-unit access
//            exec_rd_data/valid          - exec read result, one-cycle pulse
//            load_en/addr/data           - program-load write port
// Revision : 1.0 - initial release
// ============================================================================
module ifu_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int RD_LATENCY = 2    // legal range 1..7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    output logic                  ifu_busy,
    input  logic                  exec_rd_req,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_rd_valid,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int          c_depth        = 2 ** ADDR_WIDTH;
    localparam logic [2:0]  c_cnt_load     = 3'(RD_LATENCY - 1);
    localparam bit          c_single_cycle = (RD_LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_hold;

    logic                  w_port_busy;
    logic                  w_exec_rd;
    logic                  w_accept;

    // Any load or exec activity owns the array this cycle, so fetch waits.
    assign w_port_busy = load_en | exec_wr_req | exec_rd_req;
    // A read only happens when neither a load nor an exec write claims the cycle.
    assign w_exec_rd   = exec_rd_req & ~exec_wr_req & ~load_en;
    assign w_accept    = ifu_rd_req & ~w_port_busy & (r_state != ST_WAIT);
    assign ifu_busy    = (r_state == ST_WAIT) | w_port_busy;

    // ------------------------------------------------------------------------
    // Storage: single write port shared by load and exec; never reset so a
    // loaded program survives a reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end else if (exec_wr_req) begin
            r_mem[exec_addr] <= exec_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Exec read port: registered read, data held between reads.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_rd_data  <= '0;
            exec_rd_valid <= 1'b0;
        end else begin
            exec_rd_valid <= w_exec_rd;
            if (w_exec_rd) begin
                exec_rd_data <= r_mem[exec_addr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fetch FSM. The word is snapshotted into r_hold at accept so later writes
    // to the same address do not alter the in-flight response. ifu_rd_data is
    // a separate register so it keeps the last returned word even when a new
    // fetch is accepted back-to-back in RESP.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_hold       <= '0;
            ifu_rd_data  <= '0;
            ifu_rd_valid <= 1'b0;
        end else begin
            ifu_rd_valid <= 1'b0;
            case (r_state)
                ST_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        r_state      <= ST_RESP;
                        ifu_rd_valid <= 1'b1;
                        ifu_rd_data  <= r_hold;
                    end
                end
                default: begin
                    // IDLE and RESP both accept a new fetch.
                    if (w_accept) begin
                        r_hold <= r_mem[ifu_rd_addr];
                        r_cnt  <= c_cnt_load;
                        if (c_single_cycle) begin
                            r_state      <= ST_RESP;
                            ifu_rd_valid <= 1'b1;
                            ifu_rd_data  <= r_mem[ifu_rd_addr];
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
